frida_spi_master: RTL and testbench

- Host-side SPI initiator that writes the FRIDA 180-bit configuration chain through the spi_sclk/spi_sdi/spi_cs_b/spi_sdo pads.
- Lives in the FPGA test-firmware tree and drives the chip's SPI slave register.
- Accepts one full configuration word per command and shifts it out MSB-first.
- Simultaneously captures the previous chain contents returned on spi_sdo and presents them as a response word.

---
 rtl/frida_spi_pkg.sv | 39 +++
 rtl/frida_spi_clkgen.sv | 49 ++++
 rtl/frida_spi_master.sv | 167 ++++++++++++++++
 tb/tb_frida_spi_master.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frida_spi_pkg.sv
// ============================================================================
// Module      : frida_spi_pkg
// Description : Shared constants for the FRIDA configuration-chain SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package frida_spi_pkg;

    localparam int FRIDA_SPI_NBITS = 180;

    // Chain field offsets
    localparam int MUX_SEL_LSB  = 176;
    localparam int ADC_CTRL_LSB = 64;
    localparam int ADC_CTRL_W   = 7;
    localparam int DAC_AP_LSB   = 48;
    localparam int DAC_BP_LSB   = 32;
    localparam int DAC_AN_LSB   = 16;
    localparam int DAC_BN_LSB   = 0;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETUP    = 3'd1;
    localparam logic [2:0] ST_SHIFT_LO = 3'd2;
    localparam logic [2:0] ST_SHIFT_HI = 3'd3;
    localparam logic [2:0] ST_HOLD     = 3'd4;
    localparam logic [2:0] ST_GAP      = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_SETUP    = ST_SETUP,
        S_SHIFT_LO = ST_SHIFT_LO,
        S_SHIFT_HI = ST_SHIFT_HI,
        S_HOLD     = ST_HOLD,
        S_GAP      = ST_GAP
    } spi_state_t;

endpackage

`default_nettype wire

// File: rtl/frida_spi_clkgen.sv
// ============================================================================
// Module      : frida_spi_clkgen
// Description : SCLK half-period divider with end-of-phase rise/fall strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frida_spi_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    localparam int c_CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(CLK_DIV - 1);

    logic [c_CW-1:0] r_cnt;
    logic            r_sclk;
    logic            w_wrap;

    assign w_wrap = i_en && (r_cnt == c_LAST);

    // Disabled means parked: counter cleared and sclk low
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_wrap) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + c_CW'(1);
        end
    end

    assign o_sclk = r_sclk;
    assign o_rise = w_wrap && !r_sclk;
    assign o_fall = w_wrap && r_sclk;

    a_clk_div_nonzero : assert property (@(posedge clk) CLK_DIV != 0);

endmodule

`default_nettype wire

// File: rtl/frida_spi_master.sv
// ============================================================================
// Module      : frida_spi_master
// Description : Writes the FRIDA configuration chain over SPI and returns the
//               previous chain contents. FRIDA_SPI_VERIFY_EN adds readback check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frida_spi_master
    import frida_spi_pkg::*;
#(
    parameter int NBITS    = FRIDA_SPI_NBITS,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int IDLE_GAP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [NBITS-1:0] cmd_data,
    output logic             rsp_valid,
    output logic [NBITS-1:0] rsp_data,
    output logic             busy,
    output logic             verify_err,
    output logic             spi_sclk,
    output logic             spi_sdi,
    input  logic             spi_sdo,
    output logic             spi_cs_b
);

    localparam int c_BW = $clog2(NBITS);
    localparam int c_TW = 16;
    localparam logic [c_TW-1:0] c_SETUP_LAST = c_TW'(CS_SETUP - 1);
    localparam logic [c_TW-1:0] c_HOLD_LAST  = c_TW'(CS_HOLD - 1);
    localparam logic [c_TW-1:0] c_GAP_LAST   = c_TW'(IDLE_GAP - 1);

    spi_state_t       r_state, w_state_next;
    logic [c_TW-1:0]  r_tcnt;
    logic [c_BW-1:0]  r_bit;
    logic [NBITS-2:0] r_tx;
    logic [NBITS-1:0] r_rx, r_rsp_data;
    logic             r_cmd_ready, r_busy, r_cs_b, r_sdi, r_rsp_valid;
    logic             w_accept, w_clk_en, w_rise, w_fall, w_sclk;
    logic             w_last_bit, w_sample, w_done, w_cs_active;

    assign w_accept   = (r_state == S_IDLE) && cmd_valid && r_cmd_ready;
    assign w_clk_en   = (r_state == S_SHIFT_LO) || (r_state == S_SHIFT_HI);
    assign w_last_bit = (r_bit == '0);

    frida_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_clk_en),
        .o_sclk (w_sclk),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_sample     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE:     if (w_accept) w_state_next = S_SETUP;
            S_SETUP:    if (r_tcnt == c_SETUP_LAST) w_state_next = S_SHIFT_LO;
            S_SHIFT_LO: if (w_rise) w_state_next = S_SHIFT_HI;
            S_SHIFT_HI: if (w_fall) begin
                w_sample     = 1'b1;
                w_state_next = w_last_bit ? S_HOLD : S_SHIFT_LO;
            end
            S_HOLD:     if (r_tcnt == c_HOLD_LAST) begin
                w_done       = 1'b1;
                w_state_next = S_GAP;
            end
            S_GAP:      if (r_tcnt == c_GAP_LAST) w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
        w_cs_active = (w_state_next != S_IDLE) && (w_state_next != S_GAP);
    end

    // Outputs are registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_cs_b      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_tcnt      <= '0;
        end else begin
            r_cmd_ready <= (w_state_next == S_IDLE);
            r_busy      <= (w_state_next != S_IDLE);
            r_cs_b      <= !w_cs_active;
            r_rsp_valid <= w_done;
            r_tcnt      <= (w_state_next != r_state) ? '0 : r_tcnt + c_TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx       <= '0;
            r_rx       <= '0;
            r_sdi      <= 1'b0;
            r_bit      <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_tx  <= cmd_data[NBITS-2:0];
                r_sdi <= cmd_data[NBITS-1];
                r_bit <= c_BW'(NBITS - 1);
            end
            // sdi advances together with the sclk falling edge
            if (w_sample) begin
                r_rx <= {r_rx[NBITS-2:0], spi_sdo};
                if (!w_last_bit) begin
                    r_bit <= r_bit - c_BW'(1);
                    r_tx  <= {r_tx[NBITS-3:0], 1'b0};
                    r_sdi <= r_tx[NBITS-2];
                end
            end
            if (w_done) r_rsp_data <= r_rx;
        end
    end

`ifdef FRIDA_SPI_VERIFY_EN
    logic [NBITS-1:0] r_cur, r_last;
    logic             r_has_last, r_verify_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur        <= '0;
            r_last       <= '0;
            r_has_last   <= 1'b0;
            r_verify_err <= 1'b0;
        end else begin
            r_verify_err <= 1'b0;
            if (w_accept) r_cur <= cmd_data;
            if (w_done) begin
                r_verify_err <= r_has_last && (r_rx != r_last);
                r_last       <= r_cur;
                r_has_last   <= 1'b1;
            end
        end
    end

    assign verify_err = r_verify_err;
`else
    assign verify_err = 1'b0;
`endif

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign spi_sclk  = w_sclk;
    assign spi_sdi   = r_sdi;
    assign spi_cs_b  = r_cs_b;

endmodule

`default_nettype wire

// File: tb/tb_frida_spi_master.sv
// ============================================================================
// Module      : tb_frida_spi_master
// Description : Self-checking bench for frida_spi_master with a chain slave model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frida_spi_master;

    localparam int NBITS    = 180;
    localparam int CLK_DIV  = 3;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int IDLE_GAP = 2;
    localparam int c_LAT    = 1 + CS_SETUP + 2 * CLK_DIV * NBITS + CS_HOLD;
`ifdef FRIDA_SPI_VERIFY_EN
    localparam bit c_VE = 1'b1;
`else
    localparam bit c_VE = 1'b0;
`endif

    localparam logic [NBITS-1:0] c_MSB  = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [NBITS-1:0] c_ALT  = {45{4'ha}};
    localparam logic [NBITS-1:0] c_ONES = {NBITS{1'b1}};
    localparam logic [NBITS-1:0] c_MIX  = 180'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_5a5a_a5a5_f;
    localparam logic [NBITS-1:0] c_X    = {45{4'h3}};

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic [NBITS-1:0] cmd_data;
    logic             cmd_ready, rsp_valid, busy, verify_err;
    logic [NBITS-1:0] rsp_data;
    logic             spi_sclk, spi_sdi, spi_cs_b;
    logic             s_sdo = 1'b0;

    frida_spi_master #(
        .NBITS(NBITS), .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP),
        .CS_HOLD(CS_HOLD), .IDLE_GAP(IDLE_GAP)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .verify_err(verify_err), .spi_sclk(spi_sclk),
        .spi_sdi(spi_sdi), .spi_sdo(s_sdo), .spi_cs_b(spi_cs_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [NBITS-1:0] act, input logic [NBITS-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave chain: shifts sdi in at the LSB on sclk rise, drives sdo on cs_b/sclk fall
    logic [NBITS-1:0] s_chain = '0;
    logic             m_sclk = 1'b0, m_cs = 1'b1;
    bit               corrupt = 1'b0;
    int               s_idx = 0;
    int               rises = 0;

    always @(spi_sclk or spi_cs_b) begin
        if (m_cs && !spi_cs_b) begin
            s_idx = NBITS - 1;
            s_sdo = s_chain[NBITS-1] ^ (corrupt && s_idx == 3);
        end
        if (!m_sclk && spi_sclk && !spi_cs_b) begin
            s_chain = {s_chain[NBITS-2:0], spi_sdi};
            rises++;
        end
        if (m_sclk && !spi_sclk && !spi_cs_b) begin
            s_idx--;
            s_sdo = s_chain[NBITS-1] ^ (corrupt && s_idx == 3);
        end
        m_sclk = spi_sclk;
        m_cs   = spi_cs_b;
    end

    // Pin-level protocol monitor
    logic p_sclk = 1'b0, p_cs_b = 1'b1, p_sdi = 1'b0, p_rst = 1'b1;
    int   run_hi = 0, run_lo = 0, hi_gap = 0;
    bit   lo_from_fall = 1'b0, seen_xfer = 1'b0;
    int   viol_phase = 0, viol_sdi = 0, viol_cs = 0, viol_gap = 0, verr_pulses = 0;

    always @(negedge clk) begin
        if (!rst && !p_rst) begin
            if (spi_sclk && !p_sclk) begin
                if (lo_from_fall && run_lo != CLK_DIV) viol_phase++;
                run_hi = 1;
            end else if (!spi_sclk && p_sclk) begin
                if (run_hi != CLK_DIV) viol_phase++;
                run_lo = 1;
                lo_from_fall = 1'b1;
            end else if (spi_sclk) begin
                run_hi++;
            end else begin
                run_lo++;
            end
            if (spi_sdi != p_sdi && !(p_sclk && !spi_sclk) && !(p_cs_b && !spi_cs_b)) viol_sdi++;
            if (spi_cs_b != p_cs_b && (spi_sclk || p_sclk)) viol_cs++;
            if (!spi_cs_b && p_cs_b) begin
                if (seen_xfer && hi_gap < IDLE_GAP) viol_gap++;
                seen_xfer = 1'b1;
                lo_from_fall = 1'b0;
            end
            if (spi_cs_b) hi_gap++;
            else hi_gap = 0;
        end else begin
            lo_from_fall = 1'b0;
            seen_xfer = 1'b0;
            hi_gap = 0;
        end
        if (verify_err) verr_pulses++;
        p_sclk = spi_sclk;
        p_cs_b = spi_cs_b;
        p_sdi  = spi_sdi;
        p_rst  = rst;
    end

    int last_rsp = 0;

    task automatic do_xfer(input string tag, input logic [NBITS-1:0] data,
                           input logic [NBITS-1:0] exp_rsp, input bit chk_rsp,
                           input bit b2b, input bit exp_verr);
        int  t_acc, k, base;
        bit  got, ready_busy;
        cmd_data  = data;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        got = cmd_ready;
        check({tag, " accept_seen"}, got, 1);
        if (!got) return;
        t_acc = cyc;
        base  = rises;
        if (b2b) check({tag, " accept_gap"}, t_acc - last_rsp, IDLE_GAP);
        got = 1'b0;
        ready_busy = 1'b0;
        for (int j = 0; j < c_LAT + 50 && !got; j++) begin
            @(negedge clk);
            if (j == c_LAT / 2) cmd_data = ~data;
            if (rsp_valid) got = 1'b1;
            else if (cmd_ready) ready_busy = 1'b1;
        end
        check({tag, " rsp_seen"}, got, 1);
        if (!got) return;
        last_rsp = cyc;
        check({tag, " latency"}, cyc - t_acc, c_LAT);
        check({tag, " sclk_rises"}, rises - base, NBITS);
        check({tag, " chain"}, s_chain, data);
        check({tag, " ready_while_busy"}, ready_busy, 0);
        check({tag, " verify_err"}, verify_err, exp_verr);
        if (chk_rsp) check({tag, " rsp_data"}, rsp_data, exp_rsp);
    endtask

    typedef struct {
        logic [NBITS-1:0] data;
        logic [NBITS-1:0] exp_rsp;
        bit               b2b;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int k, base, nv;
        vecs[0] = '{data: c_MSB,  exp_rsp: '0,    b2b: 1'b0};
        vecs[1] = '{data: c_ALT,  exp_rsp: c_MSB, b2b: 1'b0};
        vecs[2] = '{data: c_ONES, exp_rsp: c_ALT, b2b: 1'b1};
        vecs[3] = '{data: c_MIX,  exp_rsp: c_ONES, b2b: 1'b1};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_data = '0;
        repeat (3) @(negedge clk);
        check("rst cmd_ready", cmd_ready, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst rsp_data", rsp_data, 0);
        check("rst busy", busy, 0);
        check("rst verify_err", verify_err, 0);
        check("rst sclk", spi_sclk, 0);
        check("rst sdi", spi_sdi, 0);
        check("rst cs_b", spi_cs_b, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 4; i++) begin
            if (!vecs[i].b2b) begin
                cmd_valid = 1'b0;
                repeat (4) @(negedge clk);
            end
            do_xfer($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp_rsp, 1'b1, vecs[i].b2b, 1'b0);
        end
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Abort during bit 90
        cmd_data  = 180'hdead_beef;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        base = rises;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (rises - base < 90 && k < c_LAT) begin
            @(negedge clk);
            k++;
        end
        check("abort reached_bit90", rises - base, 90);
        check("abort busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort cs_b", spi_cs_b, 1);
        check("abort sclk", spi_sclk, 0);
        check("abort rsp_valid", rsp_valid, 0);
        check("abort busy", busy, 0);
        rst = 1'b0;
        nv = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) nv++;
        end
        check("abort no_rsp", nv, 0);
        do_xfer("post_abort", 180'h5, '0, 1'b0, 1'b0, 1'b0);

        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        do_xfer("verify_a", c_X, 180'h5, 1'b1, 1'b0, 1'b0);
        corrupt = 1'b1;
        do_xfer("verify_b", c_X, c_X ^ 180'h8, 1'b1, 1'b1, c_VE);
        corrupt = 1'b0;
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);

        check("proto phase_len", viol_phase, 0);
        check("proto sdi_toggle", viol_sdi, 0);
        check("proto cs_sclk_low", viol_cs, 0);
        check("proto cs_gap", viol_gap, 0);
        check("verify_err pulses", verr_pulses, c_VE ? 1 : 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
